spi_target_regfile: RTL and testbench
=====================================

Name: spi_target_regfile

Overview:
SPI mode-0 target (responder) that sits at the far end of the I2C-to-SPI bridge's SPI master link. It receives SCK/CS_N/MOSI from the master, drives MISO and exposes a small register file of four read/write bytes plus one read-only status byte. All SPI inputs are oversampled and synchronized into the single system clock domain. No logic is clocked by SCK.

Parameters:
SYNC_STAGES, 2, synchronizer flops on each SPI input (legal range 2..3)
RESET_VAL, 32'h0000_0000, reset contents of regs_o ({reg3,reg2,reg1,reg0})

Ports:
clk  input  1  system clock; must be >= 8x SCK frequency
rst_n  input  1  asynchronous active-low reset
spi_sck_i  input  1  SPI clock from master, CPOL=0
spi_cs_n_i  input  1  active-low chip select
spi_mosi_i  input  1  master-out data, MSB first
spi_miso_o  output  1  target-out data
spi_miso_oe  output  1  MISO output enable; high while the synchronized CS_N is low
status_i  input  8  read-only status byte, readable at address 4
regs_o  output  32  register file contents {reg3,reg2,reg1,reg0}
wr_strobe_o  output  1  one-clk pulse when a register write commits
wr_addr_o  output  2  address of the last committed write; held between strobes
busy_o  output  1  high from synchronized CS_N fall until CS_N rise

Behaviour:
- Reset values: regs_o=RESET_VAL, spi_miso_o=0, spi_miso_oe=0, wr_strobe_o=0, wr_addr_o=0, busy_o=0, state=IDLE, bit counter=0.
- Synchronizers:
  - SCK, CS_N and MOSI each pass through SYNC_STAGES flops; SCK and CS_N synchronizers reset to 1.
  - Edge detect compares the last synchronizer stage with one extra delay flop.
  - A rising/falling SCK event is a single-clk pulse.
- Frame: 16 bits, MSB first.
  - Byte 0 (command): bit7=R/W (1=read), bits6:3 ignored, bits2:0=address.
  - Byte 1 (data): write data, or don't-care on a read.
- Timing: MOSI is sampled on the SCK rise event. MISO updates on the SCK fall event (mode 0).
- States:
  - IDLE: CS_N high. On CS_N fall event -> CMD, bit counter=0, MISO=0, busy_o=1.
  - CMD: shift MOSI on each rise event. On the 8th rise event, latch command and load the read shift register with the read value; -> DATA.
    - Read value: addr 0-3 = reg[addr]; addr 4 = status_i sampled that cycle; addr 5-7 = 8'h00.
  - DATA:
    - On each fall event, drive MISO from rdshift[7] then shift left. The first fall after the 8th rise presents bit7.
    - MISO is driven on both reads and writes (write frames return the old register value).
    - Shift MOSI on each rise event. On the 16th rise event:
      - Write with addr<=3: update reg[addr] in the same clk, pulse wr_strobe_o for 1 clk, set wr_addr_o=addr.
      - Write with addr>=4: discarded, no strobe.
      - -> DONE.
  - DONE: ignore further SCK edges; MISO=0. On CS_N rise -> IDLE.
- CS_N rise in any state:
  - -> IDLE within the next clk; busy_o=0, MISO=0.
  - Partial frame discarded: no register change, no strobe.
- CS_N rise on the same clk as the 16th rise event: the write commits first, then -> IDLE.
- MISO during CMD: 0.
- spi_miso_oe: follows inverted synchronized CS_N.
- SCK edges while CS_N is high: ignored.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). The next frame requires a fresh CS_N fall.
- Latency: CS_N/SCK to internal action is SYNC_STAGES+1 clk. The master must keep SCK high and low phases each >= 4 clk.

Test Plan:
- Write addr 2 = 0xA5 (MOSI 0x02,0xA5) -> one wr_strobe_o pulse, wr_addr_o=2, regs_o=0x00A50000; MISO during byte 1 = 0x00.
- Write 0x3C to addr 1, then read frame 0x81,0x00 -> MISO byte 1 = 0x3C, regs_o unchanged, no strobe.
- status_i=0x5E, read addr 4 (0x84) -> MISO 0x5E. Write to addr 6 -> no strobe, regs_o unchanged.
- CS_N raised after 11 bits of a write to addr 0 -> reg0 stays 0x00, no strobe, busy_o falls, next full frame works.
- Assert rst_n low mid-DATA after prior writes -> regs_o=RESET_VAL, MISO=0, oe=0. A 20-SCK frame writes only once and bits 17-20 are ignored.
- SCK at clk/8 with random phase jitter, 100 random read/write frames -> reads match a reference model.

Source files
------------

// File: rtl/spi_target_regfile.sv
// -----------------------------------------------------------------------------
// spi_target_regfile
//   SPI mode-0 target with four read/write byte registers (addr 0-3) and one
//   read-only status byte (addr 4). Every SPI input is oversampled into the
//   system clock domain; nothing is clocked by SCK.
//
//   Frame: 16 bits, MSB first. Byte 0 = {R/W(1=read), 4'bx, addr[2:0]}.
//   Byte 1 = write data (ignored on reads). Byte 1 of MISO always returns the
//   addressed value as it was at the end of the command byte.
//
// Ports
//   clk           system clock (>= 8x SCK)
//   rst_n         asynchronous active-low reset
//   spi_sck_i     SPI clock, CPOL=0
//   spi_cs_n_i    active-low chip select
//   spi_mosi_i    master-out data
//   spi_miso_o    target-out data
//   spi_miso_oe   MISO output enable (inverted synchronized CS_N)
//   status_i      read-only status byte (addr 4)
//   regs_o        {reg3,reg2,reg1,reg0}
//   wr_strobe_o   one-clk pulse on register write commit
//   wr_addr_o     address of last committed write
//   busy_o        high from CS_N fall until CS_N rise
// -----------------------------------------------------------------------------
module spi_target_regfile #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sck_i,
    input  logic        spi_cs_n_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oe,
    input  logic [7:0]  status_i,
    output logic [31:0] regs_o,
    output logic        wr_strobe_o,
    output logic [1:0]  wr_addr_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   sck_dly_q;
    logic                   cs_dly_q;
    logic                   arm_q;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            vld_q       <= '0;
            sck_dly_q   <= 1'b1;
            cs_dly_q    <= 1'b1;
            arm_q       <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            sck_dly_q   <= sck_s;
            cs_dly_q    <= cs_s;
            // The CS synchronizer resets high, so a CS_N held low through
            // reset would look like a fresh fall. Only accept a fall once a
            // genuine post-reset high level has been seen on CS_N.
            arm_q       <= arm_q | (vld_q[SYNC_STAGES-1] & cs_s);
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s &  sck_dly_q;
    assign cs_fall  = ~cs_s  &  cs_dly_q & arm_q;
    assign cs_rise  =  cs_s  & ~cs_dly_q;

    // ---------------------------------------------------------------- core
    state_t      state_q;
    logic [3:0]  bitcnt_q;
    logic [6:0]  shift_q;
    logic [7:0]  rdshift_q;
    logic        cmd_rd_q;
    logic [2:0]  cmd_addr_q;
    logic [31:0] regs_q;
    logic        miso_q;
    logic        strobe_q;
    logic [1:0]  wr_addr_q;
    logic        busy_q;

    logic [7:0]  new_byte;
    logic [7:0]  rd_val;

    assign new_byte = {shift_q, mosi_s};

    // Read value for the address carried by the command byte just completed.
    always_comb begin
        rd_val = '0;
        if (!new_byte[2])
            rd_val = regs_q[{new_byte[1:0], 3'b000} +: 8];
        else if (new_byte[1:0] == 2'd0)
            rd_val = status_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            rdshift_q  <= '0;
            cmd_rd_q   <= 1'b0;
            cmd_addr_q <= '0;
            regs_q     <= RESET_VAL;
            miso_q     <= 1'b0;
            strobe_q   <= 1'b0;
            wr_addr_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q  <= CMD;
                        bitcnt_q <= '0;
                        miso_q   <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                CMD: begin
                    miso_q <= 1'b0;
                    if (sck_rise) begin
                        shift_q  <= new_byte[6:0];
                        bitcnt_q <= bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            cmd_rd_q   <= new_byte[7];
                            cmd_addr_q <= new_byte[2:0];
                            rdshift_q  <= rd_val;
                            state_q    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (sck_fall) begin
                        miso_q    <= rdshift_q[7];
                        rdshift_q <= {rdshift_q[6:0], 1'b0};
                    end
                    if (sck_rise) begin
                        shift_q  <= new_byte[6:0];
                        bitcnt_q <= bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd15) begin
                            if (!cmd_rd_q && !cmd_addr_q[2]) begin
                                regs_q[{cmd_addr_q[1:0], 3'b000} +: 8] <= new_byte;
                                strobe_q  <= 1'b1;
                                wr_addr_q <= cmd_addr_q[1:0];
                            end
                            state_q <= DONE;
                            miso_q  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    miso_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase

            // Placed after the case so a commit on the same clk still lands
            // before the frame is abandoned.
            if (cs_rise) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                miso_q  <= 1'b0;
            end
        end
    end

    assign spi_miso_o  = miso_q;
    assign spi_miso_oe = ~cs_s;
    assign regs_o      = regs_q;
    assign wr_strobe_o = strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_target_regfile.sv
// -----------------------------------------------------------------------------
// tb_spi_target_regfile
//   Directed and random SPI frames against spi_target_regfile. Expected MISO
//   bytes and expected register writes are queued as frames are issued and
//   consumed when the DUT returns a byte or pulses its write strobe.
// -----------------------------------------------------------------------------
module tb_spi_target_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic [7:0]  status = 8'h00;
    logic [31:0] regs;
    logic        wr_strobe;
    logic [1:0]  wr_addr;
    logic        busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0]  model [4];
    logic [7:0]  mq [$];   // expected MISO byte 1 per frame
    logic [9:0]  wq [$];   // expected write {addr, data}

    spi_target_regfile #(
        .SYNC_STAGES(2),
        .RESET_VAL  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sck_i   (sck),
        .spi_cs_n_i  (cs_n),
        .spi_mosi_i  (mosi),
        .spi_miso_o  (miso),
        .spi_miso_oe (miso_oe),
        .status_i    (status),
        .regs_o      (regs),
        .wr_strobe_o (wr_strobe),
        .wr_addr_o   (wr_addr),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-strobe scoreboard consumer.
    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            checks++;
            assert (wq.size() > 0) else begin
                errors++;
                $error("FAIL spurious_strobe: observed=1 expected=0");
            end
            if (wq.size() > 0) begin
                logic [9:0] e;
                e = wq.pop_front();
                check("wr_addr", {30'd0, wr_addr}, {30'd0, e[9:8]});
                check("wr_data", {24'd0, regs[{wr_addr, 3'b000} +: 8]}, {24'd0, e[7:0]});
            end
        end
    end

    function automatic logic [31:0] model_regs();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    function automatic logic [7:0] exp_rd(input logic [2:0] a);
        if (a < 3'd4) return model[a[1:0]];
        if (a == 3'd4) return status;
        return 8'h00;
    endfunction

    // Clocks n bits out of 'bits' (bit n-1 first); returns MISO sampled on
    // rises 9..16. Half periods jitter between 4 and 6 clk.
    task automatic xfer(input logic [31:0] bits, input int n, output logic [7:0] rd);
        int unsigned hp;
        rd = '0;
        for (int i = 0; i < n; i++) begin
            mosi = bits[n-1-i];
            hp = 40 + $urandom_range(0, 20);
            #(hp);
            sck = 1'b1;
            if (i >= 8 && i < 16) rd = {rd[6:0], miso};
            hp = 40 + $urandom_range(0, 20);
            #(hp);
            sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] bits, input int n, output logic [7:0] rd);
        #($urandom_range(1, 9));
        cs_n = 1'b0;
        #60;
        xfer(bits, n, rd);
        #50;
        cs_n = 1'b1;
        #100;
    endtask

    task automatic do_frame(input logic rw, input logic [2:0] a, input logic [7:0] d);
        logic [7:0] rd;
        logic [7:0] cmd;
        cmd = {rw, 4'b0000, a};
        mq.push_back(exp_rd(a));
        if (!rw && a < 3'd4) begin
            wq.push_back({a[1:0], d});
            model[a[1:0]] = d;
        end
        frame({16'd0, cmd, d}, 16, rd);
        check("miso_byte", {24'd0, rd}, {24'd0, mq.pop_front()});
        check("strobe_pending", wq.size(), 0);
    endtask

    initial begin
        logic [7:0] rd;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;

        // Reset state
        #23;
        @(negedge clk);
        check("rst_regs", regs, 32'h0);
        check("rst_miso", {31'd0, miso}, 0);
        check("rst_oe", {31'd0, miso_oe}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_strobe", {31'd0, wr_strobe}, 0);
        check("rst_wr_addr", {30'd0, wr_addr}, 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Write addr 2 = 0xA5
        do_frame(1'b0, 3'd2, 8'hA5);
        check("regs_a5", regs, 32'h00A5_0000);
        check("wr_addr_held", {30'd0, wr_addr}, 2);

        // Write addr 1 = 0x3C, read it back
        do_frame(1'b0, 3'd1, 8'h3C);
        do_frame(1'b1, 3'd1, 8'h00);
        check("regs_after_read", regs, 32'h00A5_3C00);

        // Status read, write to unmapped address
        status = 8'h5E;
        do_frame(1'b1, 3'd4, 8'h00);
        do_frame(1'b0, 3'd6, 8'h77);
        check("regs_after_addr6", regs, model_regs());

        // Partial write frame to addr 0: 11 bits then CS_N rise
        frame({21'd0, 8'h00, 3'b111}, 11, rd);
        @(negedge clk);
        check("partial_regs", regs, model_regs());
        check("partial_busy", {31'd0, busy}, 0);
        check("partial_oe", {31'd0, miso_oe}, 0);
        do_frame(1'b0, 3'd0, 8'h11);
        check("after_partial_regs", regs, 32'h00A5_3C11);

        // Reset mid-DATA
        cs_n = 1'b0;
        #60;
        xfer({16'd0, 8'h03, 8'hC3}, 12, rd);
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 1);
        check("mid_oe", {31'd0, miso_oe}, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_regs", regs, 32'h0);
        check("midrst_miso", {31'd0, miso}, 0);
        check("midrst_oe", {31'd0, miso_oe}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        cs_n = 1'b1;
        sck  = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // 20-SCK frame: write addr 3 = 0x96, trailing bits ignored
        mq.push_back(exp_rd(3'd3));
        wq.push_back({2'd3, 8'h96});
        model[3] = 8'h96;
        frame({12'd0, 8'h03, 8'h96, 4'hF}, 20, rd);
        check("long_miso", {24'd0, rd}, {24'd0, mq.pop_front()});
        check("long_pending", wq.size(), 0);
        check("long_regs", regs, 32'h9600_0000);

        // Random frames
        for (int k = 0; k < 100; k++) begin
            if ($urandom_range(0, 3) == 0) status = 8'($urandom);
            do_frame(1'($urandom), 3'($urandom), 8'($urandom));
        end
        check("final_regs", regs, model_regs());
        check("final_busy", {31'd0, busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so a stuck DUT cannot hang the run.
    initial begin
        #20_000_000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
